dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 128, the number of 32-bit words in the attached data memory.
REQ-002 SHALL have derived constant AW = $clog2(DEPTH)+2, the byte-address width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have per-requester ports p0_*/p1_*: valid in 1, ready out 1, we in 1, addr in AW (byte address), funct3 in 3, wdata in 32.
REQ-006 SHALL have per-requester response ports p0_*/p1_*: rvalid out 1, rdata out 32, rerr out 1.
REQ-007 SHALL have memory-side ports mem_rd_addr out $clog2(DEPTH), mem_wr_addr out $clog2(DEPTH), mem_wr_din out 32, mem_we out 1, mem_wr_strb out 3, mem_rd_dout in 32 (asynchronous read data).

Function
REQ-008 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one transaction in flight at a time.
REQ-009 SHALL assert ready only in IDLE, only to the granted requester; a request is accepted when valid && ready at the clock edge.
REQ-010 SHALL arbitrate round-robin: if both valid, grant the port not granted last; the last-grant pointer updates only on acceptance.
REQ-011 SHALL register we, addr, funct3, wdata and the port ID at acceptance, and enter ACCESS next cycle.
REQ-012 SHALL, in ACCESS, drive mem_rd_addr = mem_wr_addr = addr[AW-1:2] and capture mem_rd_dout for loads.
REQ-013 Store funct3: 000 SB -> strb 100+addr[1:0], wdata[7:0] on din[7:0]; 001 SH -> strb 001 (offset 0) or 011 (offset 2), wdata[15:0] on din[15:0]; 010 SW -> strb 000.
REQ-014 Load funct3: 000 LB, 001 LH (sign-extend); 100 LBU, 101 LHU (zero-extend); 010 LW; the byte/half is selected by addr[1:0] (little-endian).
REQ-015 SHALL flag error when SH/LH/LHU has addr[0]=1, SW/LW has addr[1:0]!=0, or funct3 is illegal for the direction.
REQ-016 SHALL pulse mem_we for exactly the ACCESS cycle of an error-free store; mem_we=0 and mem_wr_strb=010 (nop) otherwise.
REQ-017 SHALL, in RESP, assert rvalid for one cycle on the originating port only, with rerr=error flag and rdata=loaded value (0 for stores or errors).
REQ-018 SHALL give latency: accept edge N, memory access in cycle N+1, rvalid in cycle N+2; throughput is one transaction per 3 cycles.
REQ-019 SHALL not accept a request while a port's own response is pending; back-to-back requests from one port are legal from IDLE.

Reset
REQ-020 When rst=0 at a clock edge: state=IDLE, last-grant pointer=1 (port 0 wins first), and all rvalid, rerr, rdata, mem_we=0, mem_wr_strb=010.
REQ-021 SHALL combinationally force mem_we=0 and ready=0 while rst=0, so that a reset mid-ACCESS writes nothing and an in-flight transaction is dropped with no response.

Structure
REQ-022 SHALL place funct3 codes, wr_strb codes (WORD=000, HALF_LO=001, NOP=010, HALF_HI=011, BYTE0..3=100..111) and the FSM state encoding in shared package dmem_pkg.
REQ-023 SHALL contain one combinational sub-module, dmem_align: it maps (we, funct3, addr[1:0], wdata, mem_rd_dout) to strb, din, load data and error.

Verification
REQ-024 p0 SW addr 0x08 wdata 0xDEADBEEF, then p0 LW 0x08 -> mem_we pulse with strb 000 at word 2; load rdata=0xDEADBEEF at N+2.
REQ-025 SB 0x0B data 0x80, then LB 0x0B -> strb 111; LB rdata=0xFFFFFF80; LBU rdata=0x00000080.
REQ-026 SH 0x06 data 0x1234, then LHU 0x06 -> strb 011; rdata=0x00001234; LH 0x05 -> rerr=1, rdata=0, no memory write.
REQ-027 p0 and p1 both valid continuously for 4 transactions -> grants alternate p0,p1,p0,p1; each rvalid appears only on its own port.
REQ-028 Assert rst=0 during the ACCESS cycle of SW 0x10 0xFFFFFFFF -> no mem_we pulse; word 4 unchanged; no rvalid; IDLE after reset with p0 favored.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3 codes, write-strobe codes and FSM states for the data-memory controller
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte strobes encode the lane in the low two bits: BYTE0 + offset.
    typedef enum logic [2:0] {
        STRB_WORD    = 3'b000,
        STRB_HALF_LO = 3'b001,
        STRB_NOP     = 3'b010,
        STRB_HALF_HI = 3'b011,
        STRB_BYTE0   = 3'b100,
        STRB_BYTE1   = 3'b101,
        STRB_BYTE2   = 3'b110,
        STRB_BYTE3   = 3'b111
    } strb_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_align.sv
// rtl/dmem_align.sv - combinational store-strobe/data steering, load extraction and alignment checking
module dmem_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_dout,
    output logic [2:0]  strb,
    output logic [31:0] din,
    output logic [31:0] ld_data,
    output logic        err
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign shifted  = rd_dout >> {off, 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = shifted[15:0];

    always_comb begin
        strb    = STRB_NOP;
        din     = 32'h0;
        ld_data = 32'h0;
        err     = 1'b0;
        if (we) begin
            case (funct3)
                F3_B: begin
                    strb = {1'b1, off};
                    din  = {24'h0, wdata[7:0]};
                end
                F3_H: begin
                    err  = off[0];
                    strb = off[1] ? STRB_HALF_HI : STRB_HALF_LO;
                    din  = {16'h0, wdata[15:0]};
                end
                F3_W: begin
                    err  = |off;
                    strb = STRB_WORD;
                    din  = wdata;
                end
                default: err = 1'b1;
            endcase
            if (err) begin
                strb = STRB_NOP;
            end
        end else begin
            case (funct3)
                F3_B:  ld_data = {{24{byte_sel[7]}}, byte_sel};
                F3_BU: ld_data = {24'h0, byte_sel};
                F3_H: begin
                    err     = off[0];
                    ld_data = {{16{half_sel[15]}}, half_sel};
                end
                F3_HU: begin
                    err     = off[0];
                    ld_data = {16'h0, half_sel};
                end
                F3_W: begin
                    err     = |off;
                    ld_data = rd_dout;
                end
                default: err = 1'b1;
            endcase
            if (err) begin
                ld_data = 32'h0;
            end
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - two-port round-robin data-memory controller, one transaction in flight
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter  int DEPTH = 128,
    localparam int AW    = $clog2(DEPTH) + 2,
    localparam int MW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          p0_valid,
    output logic          p0_ready,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [2:0]    p0_funct3,
    input  logic [31:0]   p0_wdata,
    output logic          p0_rvalid,
    output logic [31:0]   p0_rdata,
    output logic          p0_rerr,

    input  logic          p1_valid,
    output logic          p1_ready,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [2:0]    p1_funct3,
    input  logic [31:0]   p1_wdata,
    output logic          p1_rvalid,
    output logic [31:0]   p1_rdata,
    output logic          p1_rerr,

    output logic [MW-1:0] mem_rd_addr,
    output logic [MW-1:0] mem_wr_addr,
    output logic [31:0]   mem_wr_din,
    output logic          mem_we,
    output logic [2:0]    mem_wr_strb,
    input  logic [31:0]   mem_rd_dout
);

    state_t        state_q;
    state_t        state_d;
    logic          last_q;
    logic          grant;
    logic          accept;

    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_funct3;
    logic [31:0]   req_wdata;
    logic          req_port;

    logic [31:0]   rsp_data_q;
    logic          rsp_err_q;

    logic [2:0]    a_strb;
    logic [31:0]   a_din;
    logic [31:0]   a_ld;
    logic          a_err;

    // Port 1 wins only if port 0 is idle or port 0 was granted last.
    assign grant = p1_valid && (!p0_valid || !last_q);

    dmem_align u_align (
        .we      (req_we),
        .funct3  (req_funct3),
        .off     (req_addr[1:0]),
        .wdata   (req_wdata),
        .rd_dout (mem_rd_dout),
        .strb    (a_strb),
        .din     (a_din),
        .ld_data (a_ld),
        .err     (a_err)
    );

    assign mem_rd_addr = req_addr[AW-1:2];
    assign mem_wr_addr = req_addr[AW-1:2];
    assign mem_wr_din  = a_din;

    assign p0_rdata = p0_rvalid ? rsp_data_q : 32'h0;
    assign p1_rdata = p1_rvalid ? rsp_data_q : 32'h0;
    assign p0_rerr  = p0_rvalid & rsp_err_q;
    assign p1_rerr  = p1_rvalid & rsp_err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_funct3 <= 3'b000;
            req_wdata  <= 32'h0;
            req_port   <= 1'b0;
            rsp_data_q <= 32'h0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q     <= grant;
                req_port   <= grant;
                req_we     <= grant ? p1_we     : p0_we;
                req_addr   <= grant ? p1_addr   : p0_addr;
                req_funct3 <= grant ? p1_funct3 : p0_funct3;
                req_wdata  <= grant ? p1_wdata  : p0_wdata;
            end
            if (state_q == ST_ACCESS) begin
                rsp_data_q <= a_ld;
                rsp_err_q  <= a_err;
            end
        end
    end

    // rst gates ready, mem_we and rvalid so a reset mid-transaction has no visible effect.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        p0_ready    = 1'b0;
        p1_ready    = 1'b0;
        mem_we      = 1'b0;
        mem_wr_strb = STRB_NOP;
        p0_rvalid   = 1'b0;
        p1_rvalid   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                p0_ready = rst && !grant;
                p1_ready = rst && grant;
                accept   = (p0_ready && p0_valid) || (p1_ready && p1_valid);
                if (accept) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_we = rst && req_we && !a_err;
                if (mem_we) begin
                    mem_wr_strb = a_strb;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                p0_rvalid = rst && !req_port;
                p1_rvalid = rst && req_port;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - scoreboard bench for dmem_ctrl with a byte-level reference model
module tb_dmem_ctrl;

    localparam int DEPTH = 128;
    localparam int AW    = $clog2(DEPTH) + 2;
    localparam int MW    = $clog2(DEPTH);

    logic          clk;
    logic          rst;
    logic          p0_valid, p0_ready, p0_we, p0_rvalid, p0_rerr;
    logic [AW-1:0] p0_addr;
    logic [2:0]    p0_funct3;
    logic [31:0]   p0_wdata, p0_rdata;
    logic          p1_valid, p1_ready, p1_we, p1_rvalid, p1_rerr;
    logic [AW-1:0] p1_addr;
    logic [2:0]    p1_funct3;
    logic [31:0]   p1_wdata, p1_rdata;
    logic [MW-1:0] mem_rd_addr, mem_wr_addr;
    logic [31:0]   mem_wr_din, mem_rd_dout;
    logic          mem_we;
    logic [2:0]    mem_wr_strb;

    dmem_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_funct3(p0_funct3), .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid),
        .p0_rdata(p0_rdata), .p0_rerr(p0_rerr),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_funct3(p1_funct3), .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata), .p1_rerr(p1_rerr),
        .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_din(mem_wr_din),
        .mem_we(mem_we), .mem_wr_strb(mem_wr_strb), .mem_rd_dout(mem_rd_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Attached memory: asynchronous read, strobe-decoded synchronous write.
    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    assign mem_rd_dout = mem[mem_rd_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_wr_strb)
                3'b000:  mem[mem_wr_addr] <= mem_wr_din;
                3'b001:  mem[mem_wr_addr][15:0] <= mem_wr_din[15:0];
                3'b011:  mem[mem_wr_addr][31:16] <= mem_wr_din[15:0];
                3'b100, 3'b101, 3'b110, 3'b111:
                    mem[mem_wr_addr][{mem_wr_strb[1:0], 3'b000} +: 8] <= mem_wr_din[7:0];
                default: ;
            endcase
        end
    end

    // Reference model: accesses described as byte counts and offsets.
    function automatic void ref_access(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                                       input logic [31:0] wd, output logic err, output logic [31:0] rd,
                                       output logic wr, output logic [2:0] strb, output logic [31:0] nw,
                                       output logic [31:0] widx);
        int size, off;
        logic [31:0] word, v, mask;
        logic legal;
        off  = int'(a) % 4;
        widx = 32'(int'(a) / 4);
        word = ref_mem[widx];
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                   : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        err  = !legal || (off % size != 0);
        rd   = 32'h0;
        wr   = 1'b0;
        strb = 3'b010;
        nw   = word;
        if (!err) begin
            if (we) begin
                wr = 1'b1;
                for (int b = 0; b < size; b++) nw[8*(off+b) +: 8] = wd[8*b +: 8];
                strb = (size == 4) ? 3'b000 : (size == 2) ? ((off == 0) ? 3'b001 : 3'b011) : 3'(4 + off);
            end else begin
                v    = word >> (8 * off);
                mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
                v    = v & mask;
                if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
                rd = v;
            end
        end
    endfunction

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        rerr;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          grant_log[$];
    int          cyc = 0;
    int          free_cyc = 0;
    int          wr_cyc = -1;
    logic [31:0] wr_word;
    logic [31:0] wr_val;
    logic [2:0]  wr_strb;
    logic        m_last = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t        e;
        logic        idle, gr, err, wr;
        logic [31:0] rd, nw, widx;
        logic [2:0]  sb;
        if (rst !== 1'b1) begin
            chk("rst_p0_ready", 32'(p0_ready), 32'h0);
            chk("rst_p1_ready", 32'(p1_ready), 32'h0);
            chk("rst_mem_we", 32'(mem_we), 32'h0);
            q0.delete();
            q1.delete();
            m_last   = 1'b1;
            free_cyc = 0;
            wr_cyc   = -1;
        end else begin
            if (cyc == wr_cyc) begin
                chk("mem_we", 32'(mem_we), 32'h1);
                chk("mem_wr_addr", 32'(mem_wr_addr), wr_word);
                chk("mem_rd_addr", 32'(mem_rd_addr), wr_word);
                chk("mem_wr_strb", 32'(mem_wr_strb), 32'(wr_strb));
                ref_mem[wr_word] = wr_val;
                wr_cyc = -1;
            end else begin
                chk("mem_we_quiet", 32'(mem_we), 32'h0);
                chk("mem_wr_strb_nop", 32'(mem_wr_strb), 32'h2);
            end

            if (q0.size() > 0 && q0[0].due == cyc) begin
                e = q0.pop_front();
                chk("p0_rvalid", 32'(p0_rvalid), 32'h1);
                chk("p0_rdata", p0_rdata, e.rdata);
                chk("p0_rerr", 32'(p0_rerr), 32'(e.rerr));
            end else begin
                chk("p0_rvalid_quiet", 32'(p0_rvalid), 32'h0);
            end
            if (q1.size() > 0 && q1[0].due == cyc) begin
                e = q1.pop_front();
                chk("p1_rvalid", 32'(p1_rvalid), 32'h1);
                chk("p1_rdata", p1_rdata, e.rdata);
                chk("p1_rerr", 32'(p1_rerr), 32'(e.rerr));
            end else begin
                chk("p1_rvalid_quiet", 32'(p1_rvalid), 32'h0);
            end

            idle = (cyc >= free_cyc);
            gr   = p1_valid && (!p0_valid || !m_last);
            chk("p0_ready", 32'(p0_ready), 32'(idle && !gr));
            chk("p1_ready", 32'(p1_ready), 32'(idle && gr));
            if (idle && (gr ? p1_valid : p0_valid)) begin
                if (gr) ref_access(p1_we, p1_funct3, p1_addr, p1_wdata, err, rd, wr, sb, nw, widx);
                else    ref_access(p0_we, p0_funct3, p0_addr, p0_wdata, err, rd, wr, sb, nw, widx);
                e = '{due: cyc + 2, rdata: rd, rerr: err};
                if (gr) q1.push_back(e);
                else    q0.push_back(e);
                free_cyc = cyc + 3;
                m_last   = gr;
                grant_log.push_back(int'(gr));
                if (wr) begin
                    wr_cyc  = cyc + 1;
                    wr_word = widx;
                    wr_val  = nw;
                    wr_strb = sb;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the acceptance (ACCESS) cycle.
    task automatic do_req(input int p, input logic we, input logic [2:0] f3,
                          input logic [AW-1:0] a, input logic [31:0] wd);
        int t;
        if (p == 0) begin
            p0_we = we; p0_funct3 = f3; p0_addr = a; p0_wdata = wd; p0_valid = 1'b1;
        end else begin
            p1_we = we; p1_funct3 = f3; p1_addr = a; p1_wdata = wd; p1_valid = 1'b1;
        end
        for (t = 0; t < 40; t++) begin
            @(negedge clk);
            if (((p == 0) ? p0_ready : p1_ready) && rst) break;
        end
        if (t == 40) begin
            checks++;
            errors++;
            $display("FAIL req_timeout port=%0d actual=no_ready required=ready", p);
        end
        @(posedge clk);
        #1;
        if (p == 0) p0_valid = 1'b0;
        else        p1_valid = 1'b0;
    endtask

    task automatic rand_req(input int p);
        logic       we;
        logic [2:0] f3;
        we = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 3) != 0) begin
            if (we) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
        end
        do_req(p, we, f3, AW'($urandom_range(0, 63)), $urandom);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int gsz;
        rst = 1'b0;
        p0_valid = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_funct3 = 3'b0; p0_wdata = 32'h0;
        p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_funct3 = 3'b0; p1_wdata = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        do_req(0, 1'b1, 3'b010, 'h08, 32'hDEADBEEF);
        do_req(0, 1'b0, 3'b010, 'h08, 32'h0);
        do_req(0, 1'b1, 3'b000, 'h0B, 32'h80);
        do_req(0, 1'b0, 3'b000, 'h0B, 32'h0);
        do_req(0, 1'b0, 3'b100, 'h0B, 32'h0);
        do_req(0, 1'b1, 3'b001, 'h06, 32'h1234);
        do_req(0, 1'b0, 3'b101, 'h06, 32'h0);
        do_req(0, 1'b0, 3'b001, 'h05, 32'h0);

        do_req(0, 1'b1, 3'b010, 'h10, 32'h0BADF00D);
        repeat (3) begin @(posedge clk); #1; end
        do_req(0, 1'b1, 3'b010, 'h10, 32'hFFFFFFFF);
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        chk("reset_word4_kept", mem[4], 32'h0BADF00D);

        gsz = grant_log.size();
        fork
            begin
                do_req(0, 1'b0, 3'b010, 'h10, 32'h0);
                do_req(0, 1'b1, 3'b000, 'h21, 32'h5A);
            end
            begin
                do_req(1, 1'b0, 3'b010, 'h08, 32'h0);
                do_req(1, 1'b0, 3'b001, 'h0A, 32'h0);
            end
        join
        chk("grant_count", 32'(grant_log.size()), 32'(gsz + 4));
        if (grant_log.size() >= gsz + 4) begin
            for (int k = 0; k < 4; k++) chk($sformatf("grant_order_%0d", k), 32'(grant_log[gsz+k]), 32'(k % 2));
        end

        fork
            begin for (int i = 0; i < 50; i++) rand_req(0); end
            begin for (int j = 0; j < 50; j++) rand_req(1); end
        join

        for (int i = 0; i < 20 && (q0.size() + q1.size()) > 0; i++) @(negedge clk);
        chk("responses_drained", 32'(q0.size() + q1.size()), 32'h0);
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
